// File: rtl/pe_noc_pkg.sv
// Shared NoC definitions for the row-convolution processing element:
// packet widths, packet type codes, the row packet layout and PE states.
package pe_noc_pkg;

  localparam int PKT_W = 39;

  localparam logic [1:0] TYPE_ROW   = 2'b01;
  localparam logic [1:0] TYPE_SPIKE = 2'b10;

  typedef logic [7:0] weight_t;

  typedef struct packed {
    logic [1:0] pktType;
    logic [3:0] peRow;
    logic [3:0] kRow;
    logic [4:0] ifmap;
    weight_t    w0;
    weight_t    w1;
    weight_t    w2;
  } row_pkt_t;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FIRE  = 2'd1,
    ST_SEND  = 2'd2
  } pe_state_e;

  // One-hot row_mask bit for kernel row index 1..3, zero for anything else.
  function automatic logic [2:0] rowIdxBit(input logic [3:0] idx);
    logic [2:0] bitVec;
    case (idx)
      4'd1:    bitVec = 3'b001;
      4'd2:    bitVec = 3'b010;
      4'd3:    bitVec = 3'b100;
      default: bitVec = 3'b000;
    endcase
    return bitVec;
  endfunction

endpackage

// File: rtl/pe_row_conv_if.sv
// Handshake bundle between the packet sender, the PE and the spike receiver.
// master = environment side, slave = the processing element.
interface pe_row_conv_if;
  import pe_noc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_pkt;
  logic             out_valid;
  logic             out_ready;
  logic [PKT_W-1:0] out_pkt;
  logic             done;
  logic             err;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt, done, err
  );

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt, done, err
  );

endinterface

// File: rtl/pe_row_conv_row_mac3.sv
// Combinational 3-tap MAC over one 5-bit ifmap row, producing the partial
// sums for the three output columns of a 3x3 convolution.
module row_mac3
  import pe_noc_pkg::*;
(
  input  logic [4:0]      ifmap_i,
  input  weight_t         w0_i,
  input  weight_t         w1_i,
  input  weight_t         w2_i,
  output logic [2:0][9:0] colSum_o
);

  function automatic logic [9:0] tap(input logic bitOn, input weight_t w);
    return bitOn ? {2'b00, w} : 10'd0;
  endfunction

  // Column c sees ifmap bits [4-c:2-c]; the spike is binary so a tap is a gate.
  assign colSum_o[0] = tap(ifmap_i[4], w0_i) + tap(ifmap_i[3], w1_i) + tap(ifmap_i[2], w2_i);
  assign colSum_o[1] = tap(ifmap_i[3], w0_i) + tap(ifmap_i[2], w1_i) + tap(ifmap_i[1], w2_i);
  assign colSum_o[2] = tap(ifmap_i[2], w0_i) + tap(ifmap_i[1], w1_i) + tap(ifmap_i[0], w2_i);

endmodule

// File: rtl/pe_row_conv.sv
// Row-convolution spiking PE: accumulates three kernel rows into column psums,
// integrates them into membrane potentials and emits one spike packet per step.
module pe_row_conv
  import pe_noc_pkg::*;
#(
  parameter logic [3:0]      PE_ID     = 4'd0,
  parameter logic [7:0]      DEST_ADDR = 8'h00,
  parameter int unsigned     MEM_W     = 16,
  parameter logic [MEM_W-1:0] THRESH   = 16'd16,
  parameter int unsigned     TIMESTEPS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_row_conv_if.slave bus
);

  localparam int TS_W = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam logic [TS_W-1:0] TS_LAST = TS_W'(TIMESTEPS - 1);

  pe_state_e              state_q, state_d;
  logic [2:0][11:0]       psum_q, psum_d;
  logic [2:0][MEM_W-1:0]  pot_q, pot_d;
  logic [2:0]             rowMask_q, rowMask_d;
  logic [TS_W-1:0]        tsCnt_q, tsCnt_d;
  logic                   outValid_q, outValid_d;
  logic [PKT_W-1:0]       outPkt_q, outPkt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  row_pkt_t               pkt;
  logic [2:0][9:0]        colSum;
  logic [2:0][11:0]       psumAcc;
  logic [2:0][MEM_W-1:0]  potSat;
  logic [2:0][MEM_W-1:0]  potFire;
  logic [2:0]             spk;
  logic [2:0]             rowBit;
  logic                   inReady;
  logic                   accept;
  logic                   pktBad;

  assign pkt     = bus.in_pkt;
  assign inReady = (state_q == ST_ACCUM);
  assign accept  = bus.in_valid && inReady;
  assign rowBit  = rowIdxBit(pkt.kRow);

  // An out-of-range index yields rowBit==0, which also covers the duplicate test.
  assign pktBad = (pkt.pktType != TYPE_ROW) || (pkt.peRow != PE_ID) ||
                  (rowBit == 3'b000) || ((rowBit & rowMask_q) != 3'b000);

  row_mac3 u_mac (
    .ifmap_i  (pkt.ifmap),
    .w0_i     (pkt.w0),
    .w1_i     (pkt.w1),
    .w2_i     (pkt.w2),
    .colSum_o (colSum)
  );

  for (genvar c = 0; c < 3; c++) begin : g_col
    logic [MEM_W:0] potSum;

    assign psumAcc[c] = psum_q[c] + {2'b00, colSum[c]};
    assign potSum     = {1'b0, pot_q[c]} + (MEM_W+1)'(psum_q[c]);
    assign potSat[c]  = potSum[MEM_W] ? {MEM_W{1'b1}} : potSum[MEM_W-1:0];
    assign spk[c]     = (potSat[c] >= THRESH);
    assign potFire[c] = spk[c] ? '0 : potSat[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      psum_q     <= '0;
      pot_q      <= '0;
      rowMask_q  <= '0;
      tsCnt_q    <= '0;
      outValid_q <= 1'b0;
      outPkt_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      psum_q     <= psum_d;
      pot_q      <= pot_d;
      rowMask_q  <= rowMask_d;
      tsCnt_q    <= tsCnt_d;
      outValid_q <= outValid_d;
      outPkt_q   <= outPkt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // FIRE is entered one cycle after the mask fills; a packet accepted in that
  // gap can only be a duplicate and is dropped with err.
  always_comb begin
    state_d    = state_q;
    psum_d     = psum_q;
    pot_d      = pot_q;
    rowMask_d  = rowMask_q;
    tsCnt_d    = tsCnt_q;
    outValid_d = outValid_q;
    outPkt_d   = outPkt_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_ACCUM: begin
        if (rowMask_q == 3'b111) begin
          state_d = ST_FIRE;
        end
        if (accept) begin
          if (pktBad) begin
            err_d = 1'b1;
          end else begin
            psum_d    = psumAcc;
            rowMask_d = rowMask_q | rowBit;
          end
        end
      end

      ST_FIRE: begin
        pot_d      = potFire;
        outPkt_d   = {TYPE_SPIKE, DEST_ADDR, 2'b00, spk[0], spk[1], spk[2], 24'h0};
        outValid_d = 1'b1;
        psum_d     = '0;
        rowMask_d  = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (bus.out_ready) begin
          outValid_d = 1'b0;
          state_d    = ST_ACCUM;
          if (tsCnt_q == TS_LAST) begin
            tsCnt_d = '0;
            pot_d   = '0;
            done_d  = 1'b1;
          end else begin
            tsCnt_d = tsCnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_pkt   = outPkt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pe_row_conv.sv
// Directed self-checking bench for pe_row_conv with hand-computed spike packets.
module tb_pe_row_conv;
  import pe_noc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pe_row_conv_if bus();

  pe_row_conv #(
    .PE_ID     (4'd0),
    .DEST_ADDR (8'h00),
    .MEM_W     (16),
    .THRESH    (16'd16),
    .TIMESTEPS (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] mkRow(input logic [3:0] kRow, input logic [4:0] ifm,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [1:0] typ,
                                        input logic [3:0] pe);
    return {typ, pe, kRow, ifm, a, b, c};
  endfunction

  // spk is {col0, col1, col2}; col0 lands on bit 26.
  function automatic logic [38:0] mkSpike(input logic [2:0] spk);
    return {2'b10, 8'h00, 2'b00, spk, 24'h0};
  endfunction

  task automatic applyReset();
    bus.in_valid  = 1'b0;
    bus.in_pkt    = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [38:0] pkt);
    int n = 0;
    bus.in_pkt   = pkt;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendRows(input logic [4:0] ifm, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c);
    for (int k = 1; k <= 3; k++) applyStimulus(mkRow(4'(k), ifm, a, b, c, 2'b01, 4'd0));
  endtask

  task automatic collectOutput(output logic [38:0] pkt);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("out_valid_seen", 64'(bus.out_valid), 64'd1);
    pkt = bus.out_pkt;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic idleNoOutput(input string tag);
    repeat (4) @(posedge clk);
    #1 checkOutput(tag, 64'(bus.out_valid), 64'd0);
  endtask

  logic [38:0] got;
  logic [38:0] badPkts [3];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pkt    = '0;
    bus.out_ready = 1'b0;
    #1 applyReset();

    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_pkt", 64'(bus.out_pkt), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_err", 64'(bus.err), 64'd0);

    // All-ones rows with weights 1,2,3: 6 per row per column, 18 total.
    sendRows(5'b11111, 8'd1, 8'd2, 8'd3);
    checkOutput("lat_n0", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1 checkOutput("lat_n1", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1 checkOutput("lat_n2", 64'(bus.out_valid), 64'd1);
    checkOutput("pkt_all_fire", 64'(bus.out_pkt), 64'(mkSpike(3'b111)));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_pkt", 64'(bus.out_pkt), 64'(mkSpike(3'b111)));
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    checkOutput("xfer_valid_low", 64'(bus.out_valid), 64'd0);
    checkOutput("xfer_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("xfer_done", 64'(bus.done), 64'd0);

    // Out-of-order rows give the same result.
    applyStimulus(mkRow(4'd3, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd0));
    applyStimulus(mkRow(4'd1, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd0));
    applyStimulus(mkRow(4'd2, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd0));
    collectOutput(got);
    checkOutput("pkt_order312", 64'(got), 64'(mkSpike(3'b111)));
    checkOutput("err_clean", 64'(bus.err), 64'd0);

    // Duplicate row 2 with heavy weights must be ignored: 9 per column, no fire.
    applyStimulus(mkRow(4'd2, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    applyStimulus(mkRow(4'd2, 5'b11111, 8'd9, 8'd9, 8'd9, 2'b01, 4'd0));
    checkOutput("dup_err", 64'(bus.err), 64'd1);
    applyStimulus(mkRow(4'd3, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    applyStimulus(mkRow(4'd1, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    collectOutput(got);
    checkOutput("pkt_dup_ignored", 64'(got), 64'(mkSpike(3'b000)));

    // Bad type for row 1 must neither count toward the mask nor add psum.
    applyReset();
    applyStimulus(mkRow(4'd1, 5'b11111, 8'd9, 8'd9, 8'd9, 2'b11, 4'd0));
    checkOutput("badtype_err", 64'(bus.err), 64'd1);
    applyStimulus(mkRow(4'd2, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    applyStimulus(mkRow(4'd3, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    idleNoOutput("badtype_no_fire");
    applyStimulus(mkRow(4'd1, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    collectOutput(got);
    checkOutput("pkt_after_bad", 64'(got), 64'(mkSpike(3'b000)));

    badPkts[0] = mkRow(4'd1, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd5);
    badPkts[1] = mkRow(4'd4, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd0);
    badPkts[2] = mkRow(4'd0, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyReset();
      checkOutput("bad_pre_err", 64'(bus.err), 64'd0);
      applyStimulus(badPkts[i]);
      idleNoOutput("bad_no_valid");
      checkOutput("bad_err", 64'(bus.err), 64'd1);
    end

    // Only column 0 integrates, 3 per step; fires on step 6, done on step 10.
    applyReset();
    for (int k = 1; k <= 10; k++) begin
      sendRows(5'b10000, 8'd1, 8'd2, 8'd3);
      collectOutput(got);
      checkOutput("ts_pkt", 64'(got), 64'(mkSpike((k == 6) ? 3'b100 : 3'b000)));
      checkOutput("ts_done", 64'(bus.done), 64'((k == 10) ? 1 : 0));
    end
    @(posedge clk); #1 checkOutput("done_pulse_end", 64'(bus.done), 64'd0);
    // Pot 12 would fire with +9 unless cleared at done.
    sendRows(5'b10000, 8'd3, 8'd0, 8'd0);
    collectOutput(got);
    checkOutput("pot_cleared", 64'(got), 64'(mkSpike(3'b000)));

    // Reset mid-accumulation is immediate and discards partial psums.
    applyStimulus(mkRow(4'd1, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b10, 4'd0));
    applyStimulus(mkRow(4'd1, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd0));
    applyStimulus(mkRow(4'd2, 5'b11111, 8'd1, 8'd2, 8'd3, 2'b01, 4'd0));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_out_pkt", 64'(bus.out_pkt), 64'd0);
    checkOutput("mid_rst_done", 64'(bus.done), 64'd0);
    checkOutput("mid_rst_err", 64'(bus.err), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(mkRow(4'd3, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    idleNoOutput("mid_rst_no_fire");
    applyStimulus(mkRow(4'd1, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    applyStimulus(mkRow(4'd2, 5'b11111, 8'd1, 8'd1, 8'd1, 2'b01, 4'd0));
    collectOutput(got);
    checkOutput("mid_rst_fresh", 64'(got), 64'(mkSpike(3'b000)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
